pc_sequencer: RTL and testbench

Multi-cycle fetch/sequence controller for the Mini-MIPS core. It owns the architectural program counter and issues instruction-memory requests with a ready handshake. It latches the instruction register and steps each instruction through FETCH, DECODE, EXEC and UPDATE. In UPDATE it selects the next PC (sequential, branch, jump, jal, jr) and drives the `$ra` write-back for `jal`. It sits between instruction memory, the main control decoder, the ALU and the register file.

---
 rtl/mips_pkg.sv | 23 ++
 rtl/next_pc_calc.sv | 38 +++
 rtl/pc_sequencer.sv | 150 +++++++++++++++
 tb/tb_pc_sequencer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Mini-MIPS shared definitions.
// Sequencer states, link index and PC step.
package mips_pkg;

  typedef enum logic [1:0] {
    FETCH,
    DECODE,
    EXEC,
    UPDATE
  } pc_state_t;

  typedef struct packed {
    logic jr;
    logic jump;
    logic jal;
    logic branch;
    logic bne;
  } pc_ctrl_t;

  localparam logic [4:0]  RA_IDX_DEFAULT = 5'd31;
  localparam logic [31:0] PC_INC         = 32'd4;

endpackage

// File: rtl/next_pc_calc.sv
// Mini-MIPS next-PC selection.
// Pure combinational: jr > j/jal > taken branch > pc+4.
module next_pc_calc
  import mips_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic [25:0] i_ir,
  input  logic        i_zero_q,
  input  logic [31:0] i_rs_value,
  input  pc_ctrl_t    i_ctrl,
  output logic [31:0] o_next_pc
);

  logic [31:0] w_pc4;
  logic [31:0] w_jtgt;
  logic [31:0] w_boff;
  logic [31:0] w_btgt;
  logic        w_take;

  assign w_pc4  = i_pc + PC_INC;
  assign w_jtgt = {w_pc4[31:28], i_ir[25:0], 2'b00};
  assign w_boff = {{14{i_ir[15]}}, i_ir[15:0], 2'b00};
  assign w_btgt = w_pc4 + w_boff;
  assign w_take = i_ctrl.branch & (i_zero_q ^ i_ctrl.bne);

  // Priority select of the next PC
  always_comb begin
    o_next_pc = w_pc4;
    if (i_ctrl.jr) begin
      o_next_pc = i_rs_value;
    end else if (i_ctrl.jump | i_ctrl.jal) begin
      o_next_pc = w_jtgt;
    end else if (w_take) begin
      o_next_pc = w_btgt;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Mini-MIPS fetch/sequence controller.
// Owns PC and IR, steps FETCH/DECODE/EXEC/UPDATE.
module pc_sequencer
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [4:0]  RA_IDX   = RA_IDX_DEFAULT
)
(
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        dec_valid,
  input  logic        alu_done,
  input  logic        zero,
  input  logic        Jump,
  input  logic        Jal,
  input  logic        Jr,
  input  logic        Branch,
  input  logic        Bne,
  input  logic [31:0] rs_value,
  output logic [31:0] pc,
  output logic        ra_we,
  output logic [4:0]  ra_waddr,
  output logic [31:0] ra_wdata
);

  pc_state_t   r_state;
  pc_state_t   w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic        r_zero_q;
  logic        r_run;
  logic        r_ra_we;
  logic [31:0] r_ra_wdata;
  logic        w_req;
  logic        w_dec;
  logic        w_fetch_go;
  logic        w_exec_go;
  logic        w_upd;
  logic [31:0] w_next_pc;
  pc_ctrl_t    w_ctrl;

  assign w_ctrl.jr     = Jr;
  assign w_ctrl.jump   = Jump;
  assign w_ctrl.jal    = Jal;
  assign w_ctrl.branch = Branch;
  assign w_ctrl.bne    = Bne;

  assign w_fetch_go = w_req & imem_ready;
  assign w_exec_go  = (r_state == EXEC) & alu_done;

  next_pc_calc u_npc (
    .i_pc       (r_pc),
    .i_ir       (r_ir[25:0]),
    .i_zero_q   (r_zero_q),
    .i_rs_value (rs_value),
    .i_ctrl     (w_ctrl),
    .o_next_pc  (w_next_pc)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and state-decoded outputs
  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    w_dec       = 1'b0;
    w_upd       = 1'b0;
    unique case (r_state)
      FETCH: begin
        w_req = r_run;
        if (w_req & imem_ready) begin
          w_state_nxt = DECODE;
        end
      end
      DECODE: begin
        w_dec       = 1'b1;
        w_state_nxt = EXEC;
      end
      EXEC: begin
        if (alu_done) begin
          w_state_nxt = UPDATE;
        end
      end
      UPDATE: begin
        w_upd       = 1'b1;
        w_state_nxt = FETCH;
      end
      default: begin
        w_state_nxt = FETCH;
      end
    endcase
  end

  // r_run holds fetch off for the first cycle out of reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc     <= RESET_PC;
      r_ir     <= 32'd0;
      r_zero_q <= 1'b0;
      r_run    <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (w_fetch_go) begin
        r_ir <= imem_rdata;
      end
      if (w_exec_go) begin
        r_zero_q <= zero;
      end
      if (w_upd) begin
        r_pc <= w_next_pc;
      end
    end
  end

  // Link write registered on entry to UPDATE so ra_we is Moore
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ra_we    <= 1'b0;
      r_ra_wdata <= 32'd0;
    end else begin
      r_ra_we <= w_exec_go & Jal;
      if (w_exec_go) begin
        r_ra_wdata <= r_pc + PC_INC;
      end
    end
  end

  assign imem_req  = w_req;
  assign imem_addr = r_pc;
  assign instr     = r_ir;
  assign dec_valid = w_dec;
  assign pc        = r_pc;
  assign ra_we     = r_ra_we;
  assign ra_waddr  = RA_IDX;
  assign ra_wdata  = r_ra_wdata;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer and next_pc_calc.
// Randomized instruction stream against a PC model.
module tb_pc_sequencer;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] instr;
  logic        dec_valid;
  logic        alu_done = 1'b0;
  logic        zero = 1'b0;
  logic        Jump = 1'b0;
  logic        Jal = 1'b0;
  logic        Jr = 1'b0;
  logic        Branch = 1'b0;
  logic        Bne = 1'b0;
  logic [31:0] rs_value = 32'd0;
  logic [31:0] pc;
  logic        ra_we;
  logic [4:0]  ra_waddr;
  logic [31:0] ra_wdata;

  logic [31:0] t_pc = 32'd0;
  logic [25:0] t_ir = 26'd0;
  logic        t_z = 1'b0;
  logic [31:0] t_rs = 32'd0;
  pc_ctrl_t    t_ctrl;
  logic [31:0] t_npc;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  logic [31:0] m_pc;
  logic [31:0] m_ir;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pc_sequencer #(
    .RESET_PC (32'h0000_0000),
    .RA_IDX   (5'd31)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .dec_valid  (dec_valid),
    .alu_done   (alu_done),
    .zero       (zero),
    .Jump       (Jump),
    .Jal        (Jal),
    .Jr         (Jr),
    .Branch     (Branch),
    .Bne        (Bne),
    .rs_value   (rs_value),
    .pc         (pc),
    .ra_we      (ra_we),
    .ra_waddr   (ra_waddr),
    .ra_wdata   (ra_wdata)
  );

  next_pc_calc u_npc (
    .i_pc       (t_pc),
    .i_ir       (t_ir),
    .i_zero_q   (t_z),
    .i_rs_value (t_rs),
    .i_ctrl     (t_ctrl),
    .o_next_pc  (t_npc)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ctl = {jr, jump, jal, branch, bne}
  function automatic logic [31:0] ref_next(
    input logic [31:0] p, input logic [31:0] ir,
    input logic z, input logic [31:0] rs,
    input logic [4:0] ctl);
    logic [31:0] p4;
    int off;
    p4 = p + 32'd4;
    off = int'($signed(ir[15:0])) * 4;
    if (ctl[4]) return rs;
    if (ctl[3] || ctl[2])
      return (p4 & 32'hF000_0000) | ({6'd0, ir[25:0]} << 2);
    if (ctl[1] && (z != ctl[0])) return p4 + off;
    return p4;
  endfunction

  task automatic scramble_ctl();
    {Jr, Jump, Jal, Branch, Bne} = 5'($urandom);
    rs_value = $urandom;
  endtask

  task automatic run_instr(input logic [31:0] word,
                           input logic [4:0] ctl,
                           input logic z,
                           input logic [31:0] rs,
                           input int fst,
                           input int est);
    logic [31:0] exp_pc;
    chk("fetch_req", 32'(imem_req), 32'd1);
    chk("fetch_addr", imem_addr, m_pc);
    chk("fetch_pc", pc, m_pc);
    for (int i = 0; i < fst; i++) begin
      imem_ready = 1'b0;
      imem_rdata = $urandom;
      @(negedge clk);
      chk("stall_req", 32'(imem_req), 32'd1);
      chk("stall_addr", imem_addr, m_pc);
      chk("stall_ir", instr, m_ir);
      chk("stall_dv", 32'(dec_valid), 32'd0);
    end
    imem_ready = 1'b1;
    imem_rdata = word;
    @(negedge clk);
    m_ir = word;
    chk("dec_valid", 32'(dec_valid), 32'd1);
    chk("dec_instr", instr, word);
    chk("dec_req", 32'(imem_req), 32'd0);
    imem_ready = 1'($urandom);
    imem_rdata = $urandom;
    {Jr, Jump, Jal, Branch, Bne} = ctl;
    rs_value = rs;
    @(negedge clk);
    chk("exec_dv", 32'(dec_valid), 32'd0);
    for (int i = 0; i < est; i++) begin
      alu_done = 1'b0;
      zero = 1'($urandom);
      @(negedge clk);
      chk("exec_ra_we", 32'(ra_we), 32'd0);
    end
    alu_done = 1'b1;
    zero = z;
    @(negedge clk);
    chk("upd_ra_we", 32'(ra_we), 32'(ctl[2]));
    if (ctl[2]) chk("upd_ra_wdata", ra_wdata, m_pc + 32'd4);
    chk("upd_ra_waddr", 32'(ra_waddr), 32'd31);
    chk("upd_pc", pc, m_pc);
    exp_pc = ref_next(m_pc, m_ir, z, rs, ctl);
    alu_done = 1'($urandom);
    zero = 1'($urandom);
    imem_ready = 1'($urandom);
    @(negedge clk);
    m_pc = exp_pc;
    chk("next_pc", pc, m_pc);
    chk("after_ra_we", 32'(ra_we), 32'd0);
    chk("after_req", 32'(imem_req), 32'd1);
    scramble_ctl();
  endtask

  initial begin : main
    int c0;
    logic [4:0] ctl;
    t_ctrl = '0;
    scramble_ctl();
    imem_ready = 1'b1;
    alu_done = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_pc", pc, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_dv", 32'(dec_valid), 32'd0);
    chk("rst_ra_we", 32'(ra_we), 32'd0);
    chk("rst_ra_waddr", 32'(ra_waddr), 32'd31);
    chk("rst_ra_wdata", ra_wdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    m_pc = 32'd0;
    m_ir = 32'd0;

    for (int k = 0; k < 3; k++) begin
      c0 = cyc;
      run_instr($urandom, 5'b00000, 1'b0, 32'd0, 0, 0);
      chk("seq_latency", 32'(cyc - c0), 32'd4);
      chk("seq_pc", pc, 32'(4 * (k + 1)));
    end

    run_instr($urandom, 5'b00000, 1'b1, 32'd0, 5, 2);

    run_instr({6'h02, 26'h40}, 5'b01000, 1'b0, 32'd0, 0, 0);
    chk("jump_0x100", pc, 32'h100);
    run_instr({16'h1000, 16'hFFFE}, 5'b00010, 1'b1, 32'd0, 1, 0);
    chk("br_back", pc, 32'h0FC);
    run_instr($urandom, 5'b10000, 1'b0, 32'h100, 0, 1);
    run_instr({16'h1400, 16'hFFFE}, 5'b00011, 1'b1, 32'd0, 0, 0);
    chk("bne_fall", pc, 32'h104);

    run_instr($urandom, 5'b10000, 1'b0, 32'h1000_0010, 0, 0);
    run_instr({6'h03, 26'h40}, 5'b00100, 1'b0, 32'd0, 2, 1);
    chk("jal_pc", pc, 32'h1000_0100);
    chk("jal_wdata", ra_wdata, 32'h1000_0014);

    run_instr({16'h1000, 16'h0040}, 5'b10010, 1'b1, 32'h200, 0, 0);
    chk("jr_prio", pc, 32'h200);
    run_instr({6'h03, 26'h3FF}, 5'b10100, 1'b0, 32'h300, 0, 0);
    chk("jalr_pc", pc, 32'h300);
    chk("jalr_wdata", ra_wdata, 32'h204);

    run_instr($urandom, 5'b10000, 1'b0, 32'hFFFF_FFFC, 0, 0);
    run_instr($urandom, 5'b00000, 1'b1, 32'd0, 0, 0);
    chk("wrap", pc, 32'd0);

    for (int k = 0; k < 40; k++) begin
      ctl = 5'($urandom);
      if ($urandom_range(0, 2) == 0) ctl = 5'd0;
      run_instr($urandom, ctl, 1'($urandom),
                $urandom & 32'hFFFF_FFFC,
                $urandom_range(0, 3), $urandom_range(0, 3));
    end

    imem_ready = 1'b1;
    imem_rdata = {6'h03, 26'h55};
    @(negedge clk);
    {Jr, Jump, Jal, Branch, Bne} = 5'b00100;
    @(negedge clk);
    alu_done = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_pc", pc, 32'd0);
    chk("mid_rst_instr", instr, 32'd0);
    chk("mid_rst_ra_we", 32'(ra_we), 32'd0);
    chk("mid_rst_req", 32'(imem_req), 32'd0);
    chk("mid_rst_dv", 32'(dec_valid), 32'd0);
    chk("mid_rst_wdata", ra_wdata, 32'd0);
    @(negedge clk);
    chk("mid_rst_ra_we2", 32'(ra_we), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    m_pc = 32'd0;
    m_ir = 32'd0;
    run_instr($urandom, 5'b00000, 1'b0, 32'd0, 1, 1);
    chk("post_rst_pc", pc, 32'd4);

    for (int k = 0; k < 30; k++) begin
      t_pc = $urandom;
      t_ir = 26'($urandom);
      t_z = 1'($urandom);
      t_rs = $urandom;
      ctl = 5'($urandom);
      t_ctrl = pc_ctrl_t'(ctl);
      #1;
      chk("npc_rand", t_npc,
          ref_next(t_pc, {6'd0, t_ir}, t_z, t_rs, ctl));
    end
    t_pc = 32'h100;
    t_ir = 26'h000FFFE;
    t_z = 1'b1;
    t_ctrl = pc_ctrl_t'(5'b00010);
    #1;
    chk("npc_br_back", t_npc, 32'h0FC);
    t_ctrl = pc_ctrl_t'(5'b00001);
    #1;
    chk("npc_bne_only", t_npc, 32'h104);
    t_pc = 32'hFFFF_FFFC;
    t_ctrl = '0;
    #1;
    chk("npc_wrap", t_npc, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
